// File: rtl/risc16_pkg.sv
// rtl/risc16_pkg.sv - shared risc16 constants and boot controller state type
package risc16_pkg;

  localparam int IMEM_ADDR_W = 4;

  typedef enum logic [2:0] {
    BOOT_IDLE,
    BOOT_LOAD_LO,
    BOOT_LOAD_HI,
    BOOT_WRITE,
    BOOT_CHECK,
    BOOT_RELEASE,
    BOOT_RUN,
    BOOT_ERROR
  } boot_state_e;

  function automatic logic boot_accepts_byte(input boot_state_e s);
    return (s == BOOT_LOAD_LO) || (s == BOOT_LOAD_HI) || (s == BOOT_CHECK);
  endfunction

endpackage

// File: rtl/imem_boot_ctrl_if.sv
// rtl/imem_boot_ctrl_if.sv - program byte stream in, instruction-RAM write port out
interface imem_boot_ctrl_if
  import risc16_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W
);
  logic [7:0]        byte_data;
  logic              byte_valid;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_wdata;

  // master supplies program bytes; slave is the boot controller writing the RAM
  modport master (output byte_data, byte_valid,
                  input  byte_ready, imem_we, imem_addr, imem_wdata);
  modport slave  (input  byte_data, byte_valid,
                  output byte_ready, imem_we, imem_addr, imem_wdata);
endinterface

// File: rtl/imem_boot_csum.sv
// rtl/imem_boot_csum.sv - running XOR of accepted program bytes
module imem_boot_csum (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic [7:0] byte_i,
  output logic [7:0] csum_o
);
  logic [7:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (clr_i) begin
      csum_d = '0;
    end else if (en_i) begin
      csum_d = csum_q ^ byte_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign csum_o = csum_q;
endmodule

// File: rtl/imem_boot_ctrl_core.sv
// rtl/imem_boot_ctrl_core.sv - boot load FSM; IMEM_BOOT_CSUM_EN adds the checksum byte check
module imem_boot_ctrl_core
  import risc16_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] len_i,
  imem_boot_ctrl_if.slave   bus,
  output logic              cpu_rst_o,
  output logic              execute_en_o,
  output logic              done_o,
  output logic              err_o
);
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

  boot_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, total_q, total_d, cnt_inc;
  logic [15:0]      word_q, word_d;
  logic             ready_q, ready_d, we_q, we_d, cpu_rst_q, cpu_rst_d;
  logic             exec_q, exec_d, done_q, done_d;
  logic             hs;

  assign hs      = bus.byte_valid && ready_q;
  assign cnt_inc = cnt_q + CNT_W'(1);

`ifdef IMEM_BOOT_CSUM_EN
  logic [7:0] csum;
  logic       csum_ok;
  logic       err_q, err_d;

  imem_boot_csum u_csum (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (start_i),
    .en_i   (hs && !start_i && (state_q == BOOT_LOAD_LO || state_q == BOOT_LOAD_HI)),
    .byte_i (bus.byte_data),
    .csum_o (csum)
  );
  assign csum_ok = (csum == bus.byte_data);
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= BOOT_IDLE;
      cnt_q     <= '0;
      total_q   <= '0;
      word_q    <= '0;
      ready_q   <= 1'b0;
      we_q      <= 1'b0;
      cpu_rst_q <= 1'b1;
      exec_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef IMEM_BOOT_CSUM_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      total_q   <= total_d;
      word_q    <= word_d;
      ready_q   <= ready_d;
      we_q      <= we_d;
      cpu_rst_q <= cpu_rst_d;
      exec_q    <= exec_d;
      done_q    <= done_d;
`ifdef IMEM_BOOT_CSUM_EN
      err_q     <= err_d;
`endif
    end
  end

  // start_i overrides every state, so a byte offered in the same cycle is dropped
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    total_d = total_q;
    word_d  = word_q;
    if (start_i) begin
      state_d = BOOT_LOAD_LO;
      cnt_d   = '0;
      total_d = (len_i == '0) ? FULL_CNT : CNT_W'(len_i);
    end else begin
      case (state_q)
        BOOT_LOAD_LO: if (hs) begin
          word_d[7:0] = bus.byte_data;
          state_d     = BOOT_LOAD_HI;
        end
        BOOT_LOAD_HI: if (hs) begin
          word_d[15:8] = bus.byte_data;
          state_d      = BOOT_WRITE;
        end
        BOOT_WRITE: begin
          cnt_d = cnt_inc;
          if (cnt_inc == total_q) begin
`ifdef IMEM_BOOT_CSUM_EN
            state_d = BOOT_CHECK;
`else
            state_d = BOOT_RELEASE;
`endif
          end else begin
            state_d = BOOT_LOAD_LO;
          end
        end
`ifdef IMEM_BOOT_CSUM_EN
        BOOT_CHECK: if (hs) begin
          state_d = csum_ok ? BOOT_RELEASE : BOOT_ERROR;
        end
`endif
        BOOT_RELEASE: state_d = BOOT_RUN;
        default:      state_d = state_q;
      endcase
    end
  end

  // outputs are decoded from the next state so the registers track state_q exactly
  always_comb begin
    ready_d   = boot_accepts_byte(state_d);
    we_d      = (state_d == BOOT_WRITE);
    cpu_rst_d = !((state_d == BOOT_RELEASE) || (state_d == BOOT_RUN));
    exec_d    = (state_d == BOOT_RUN);
    done_d    = (state_d == BOOT_RUN);
`ifdef IMEM_BOOT_CSUM_EN
    err_d     = (state_d == BOOT_ERROR);
`endif
  end

  assign bus.byte_ready = ready_q;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = cnt_q[ADDR_W-1:0];
  assign bus.imem_wdata = word_q;
  assign cpu_rst_o      = cpu_rst_q;
  assign execute_en_o   = exec_q;
  assign done_o         = done_q;
`ifdef IMEM_BOOT_CSUM_EN
  assign err_o          = err_q;
`else
  assign err_o          = 1'b0;
`endif
endmodule

// File: rtl/imem_boot_ctrl.sv
// rtl/imem_boot_ctrl.sv - instruction-RAM boot loader top; IMEM_BOOT_CSUM_EN enables checksum
module imem_boot_ctrl
  import risc16_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] len_i,
  input  logic [7:0]        byte_i,
  input  logic              byte_valid_i,
  output logic              byte_ready_o,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [15:0]       imem_wdata_o,
  output logic              cpu_rst_o,
  output logic              execute_en_o,
  output logic              done_o,
  output logic              err_o
);
  imem_boot_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  assign bus.byte_data  = byte_i;
  assign bus.byte_valid = byte_valid_i;
  assign byte_ready_o   = bus.byte_ready;
  assign imem_we_o      = bus.imem_we;
  assign imem_addr_o    = bus.imem_addr;
  assign imem_wdata_o   = bus.imem_wdata;

  imem_boot_ctrl_core #(.ADDR_W(ADDR_W)) u_core (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .len_i        (len_i),
    .bus          (bus.slave),
    .cpu_rst_o    (cpu_rst_o),
    .execute_en_o (execute_en_o),
    .done_o       (done_o),
    .err_o        (err_o)
  );
endmodule

// File: doc/imem_boot_ctrl.md
IMEM_BOOT_CTRL -- requirements
Module: imem_boot_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, instruction-RAM word-address width (16 words).
REQ-002 SHALL have clk_i  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have rst_i  input  1  reset, synchronous and active-high.
REQ-004 SHALL have start_i  input  1  pulse: begin (re)load.
REQ-005 SHALL have len_i  input  ADDR_W  word count, sampled with start_i; 0 means 2^ADDR_W.
REQ-006 SHALL have byte_i  input  8  program byte stream.
REQ-007 SHALL have byte_valid_i  input  1  byte_i valid.
REQ-008 SHALL have byte_ready_o  output  1  byte accepted when valid and ready both high.
REQ-009 SHALL have imem_we_o  output  1  instruction-RAM write strobe.
REQ-010 SHALL have imem_addr_o  output  ADDR_W  write address.
REQ-011 SHALL have imem_wdata_o  output  16  write data.
REQ-012 SHALL have cpu_rst_o  output  1  CPU core reset, active-high.
REQ-013 SHALL have execute_en_o  output  1  drives the CPU execute_en_i.
REQ-014 SHALL have done_o  output  1  load finished, CPU released.
REQ-015 SHALL have err_o  output  1  load failed (checksum variant only).

Function
REQ-016 SHALL implement states IDLE, LOAD_LO, LOAD_HI, WRITE, CHECK, RELEASE, RUN, ERROR.
REQ-017 start_i in any state SHALL latch len_i, clear word counter and checksum, and enter LOAD_LO next cycle; it takes priority over all other events.
REQ-018 A byte handshake coinciding with start_i SHALL be discarded.
REQ-019 byte_ready_o SHALL be a registered state decode: high only in LOAD_LO, LOAD_HI and CHECK.
REQ-020 Bytes SHALL be little-endian: LOAD_LO accepts bits [7:0], LOAD_HI accepts bits [15:8], then WRITE.
REQ-021 WRITE SHALL last exactly one cycle, with imem_we_o=1, imem_addr_o=word counter and imem_wdata_o=assembled word; imem_we_o SHALL be 0 in every other state.
REQ-022 After WRITE the controller SHALL enter LOAD_LO if words remain, else CHECK (macro on) or RELEASE (macro off).
REQ-023 The word counter SHALL increment after each WRITE and never wrap; the last address written SHALL be len-1 (2^ADDR_W-1 when len_i=0).
REQ-024 Without valid bytes the controller SHALL wait indefinitely in LOAD_LO, LOAD_HI or CHECK.
REQ-025 cpu_rst_o SHALL be 1 in every state except RELEASE and RUN.
REQ-026 RELEASE SHALL last one cycle with cpu_rst_o=0 and execute_en_o=0, then enter RUN.
REQ-027 RUN SHALL hold execute_en_o=1, done_o=1 and cpu_rst_o=0 until start_i or rst_i.
REQ-028 ERROR SHALL hold err_o=1, cpu_rst_o=1 and execute_en_o=0 until start_i or rst_i.

Reset
REQ-029 rst_i SHALL, at the next edge, force IDLE with cpu_rst_o=1 and all other outputs 0, counters 0; mid-load reset SHALL abandon the load with no further RAM writes.

Configuration
REQ-030 With IMEM_BOOT_CSUM_EN defined, CHECK SHALL accept one byte equal to the XOR of all program bytes: match goes to RELEASE, mismatch goes to ERROR.
REQ-031 Without IMEM_BOOT_CSUM_EN, CHECK and ERROR SHALL be unreachable, err_o SHALL be tied to 0, and no checksum logic SHALL be synthesised.

Structure
REQ-032 The state enum and IMEM_ADDR_W constant SHALL reside in the shared risc16 package.
REQ-033 The XOR accumulator SHALL be the sub-module imem_boot_csum, instantiated only under IMEM_BOOT_CSUM_EN.

Verification
REQ-034 Scenario: len=2, bytes 34 12 78 56 -> writes addr0=0x1234 and addr1=0x5678; RELEASE then RUN; execute_en_o=1 the cycle after cpu_rst_o falls.
REQ-035 Scenario: len=0, 32 bytes -> 16 writes to addr 0..15; no write to addr 0 after addr 15.
REQ-036 Scenario: macro on, bytes 01 02 then checksum 03 -> RUN; checksum 00 instead -> ERROR with err_o=1 and cpu_rst_o=1.
REQ-037 Scenario: byte_valid_i gapped for 5 cycles mid-word -> same RAM contents as a gapless stream; imem_we_o pulses are exactly one cycle.
REQ-038 Scenario: start_i asserted in RUN -> execute_en_o=0 and cpu_rst_o=1 next cycle; reload overwrites from addr 0.
REQ-039 Scenario: rst_i asserted in LOAD_HI -> IDLE next cycle with no write for the partial word.
